// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequences one CB-class shift/rotate request through the ALU
// shifter. It drives the load/shift/result controls and captures the result and
// flags, then returns them on a valid/ready response port.
// SWAP is executed as SWAP_PASSES chained RLC passes through the shifter.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | req_ready high, waiting for a request
//   LOAD   | operand on alu_bus, ALU latches loaded, shift-out bit captured
//   RES    | shifter result read back into operand reg, Z captured
//   DONE   | resp_valid high, holding result/flags until resp_ready
module alu_shift_seq #(
  parameter int SWAP_PASSES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_operand,
  input  logic       req_carry,
  input  logic       flush,
  output logic [7:0] alu_bus,
  output logic       alu_ld,
  output logic       alu_sh_oe,
  output logic       alu_res_oe,
  output logic       alu_si,
  output logic       alu_dir_r,
  input  logic       alu_shift_out,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_result,
  output logic [3:0] resp_flags
);

  localparam int PASS_W = (SWAP_PASSES > 2) ? $clog2(SWAP_PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(SWAP_PASSES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RES  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [7:0]        opnd_q, opnd_d;
  logic              cin_q, cin_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  logic              in_alu;
  logic              shift_si;
  logic              shift_dir_r;

  // Next-state and datapath capture; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    cin_d   = cin_q;
    c_d     = c_q;
    z_d     = z_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = req_op;
          opnd_d  = req_operand;
          cin_d   = req_carry;
          c_d     = 1'b0;
          z_d     = 1'b0;
          pass_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        c_d     = alu_shift_out;
        state_d = S_RES;
      end
      S_RES: begin
        opnd_d = alu_result;
        z_d    = alu_zero;
        if (op_q == OP_SWAP && pass_q != LAST_PASS) begin
          pass_d  = pass_q + PASS_W'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      pass_d  = '0;
    end
  end

  // Sequencer state and captured operand/flags; reset discards everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      opnd_q  <= 8'd0;
      cin_q   <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cin_q   <= cin_d;
      c_q     <= c_d;
      z_q     <= z_d;
      pass_q  <= pass_d;
    end
  end

  // Shift-in bit and direction per opcode; the operand reg only changes at the
  // end of RES, so these hold their LOAD values through RES.
  always_comb begin
    shift_si    = 1'b0;
    shift_dir_r = 1'b0;
    case (op_q)
      OP_RLC:  begin shift_si = opnd_q[7]; shift_dir_r = 1'b0; end
      OP_RRC:  begin shift_si = opnd_q[0]; shift_dir_r = 1'b1; end
      OP_RL:   begin shift_si = cin_q;     shift_dir_r = 1'b0; end
      OP_RR:   begin shift_si = cin_q;     shift_dir_r = 1'b1; end
      OP_SLA:  begin shift_si = 1'b0;      shift_dir_r = 1'b0; end
      OP_SRA:  begin shift_si = opnd_q[7]; shift_dir_r = 1'b1; end
      OP_SWAP: begin shift_si = opnd_q[7]; shift_dir_r = 1'b0; end
      OP_SRL:  begin shift_si = 1'b0;      shift_dir_r = 1'b1; end
      default: begin shift_si = 1'b0;      shift_dir_r = 1'b0; end
    endcase
  end

  // ALU control and response outputs decoded from state; all quiet outside use.
  always_comb begin
    in_alu      = (state_q == S_LOAD) || (state_q == S_RES);
    req_ready   = (state_q == S_IDLE);
    alu_bus     = in_alu ? opnd_q : 8'd0;
    alu_si      = in_alu & shift_si;
    alu_dir_r   = in_alu & shift_dir_r;
    alu_ld      = (state_q == S_LOAD);
    alu_sh_oe   = (state_q == S_LOAD);
    alu_res_oe  = (state_q == S_RES);
    resp_valid  = (state_q == S_DONE);
    resp_result = resp_valid ? opnd_q : 8'd0;
    // SWAP reports C=0 regardless of the bit rotated out on the last pass.
    resp_flags  = resp_valid ? {z_q, 1'b0, 1'b0, c_q & (op_q != OP_SWAP)} : 4'd0;
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a behavioural shifter ALU.
module tb_alu_shift_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [7:0] req_operand;
  logic       req_carry, flush;
  logic [7:0] alu_bus;
  logic       alu_ld, alu_sh_oe, alu_res_oe, alu_si, alu_dir_r;
  logic       alu_shift_out;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_result;
  logic [3:0] resp_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural shifter: shift-out and result derived from bus/si/dir.
  assign alu_shift_out = alu_dir_r ? alu_bus[0] : alu_bus[7];
  assign alu_result    = alu_dir_r ? {alu_si, alu_bus[7:1]} : {alu_bus[6:0], alu_si};
  assign alu_zero      = (alu_result == 8'd0);

  alu_shift_seq #(.SWAP_PASSES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_operand(req_operand), .req_carry(req_carry), .flush(flush),
    .alu_bus(alu_bus), .alu_ld(alu_ld), .alu_sh_oe(alu_sh_oe),
    .alu_res_oe(alu_res_oe), .alu_si(alu_si), .alu_dir_r(alu_dir_r),
    .alu_shift_out(alu_shift_out), .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected si/dir_r per opcode, written from the opcode table.
  task automatic exp_ctl(input logic [2:0] op, input logic [7:0] b, input logic cin,
                         output logic si, output logic dr);
    case (op)
      3'd0: begin si = b[7]; dr = 1'b0; end
      3'd1: begin si = b[0]; dr = 1'b1; end
      3'd2: begin si = cin;  dr = 1'b0; end
      3'd3: begin si = cin;  dr = 1'b1; end
      3'd4: begin si = 1'b0; dr = 1'b0; end
      3'd5: begin si = b[7]; dr = 1'b1; end
      3'd6: begin si = b[7]; dr = 1'b0; end
      default: begin si = 1'b0; dr = 1'b1; end
    endcase
  endtask

  // Issue a request and walk its LOAD/RES pairs, ending with DONE checked.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] opnd,
                        input logic cin, input int passes,
                        input logic [7:0] exp_res, input logic [3:0] exp_flags);
    logic [7:0] b;
    logic si, dr;
    b = opnd;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_operand = opnd; req_carry = cin;
    tick();
    req_valid = 1'b0;
    for (int p = 0; p < passes; p++) begin
      exp_ctl(op, b, cin, si, dr);
      check({tag, "_load_ctl"}, {28'd0, alu_ld, alu_sh_oe, alu_res_oe, req_ready}, 32'b1100);
      check({tag, "_load_bus"}, 32'(alu_bus), 32'(b));
      check({tag, "_load_si_dir"}, {30'd0, alu_si, alu_dir_r}, {30'd0, si, dr});
      check({tag, "_load_nvalid"}, 32'(resp_valid), 32'd0);
      tick();
      check({tag, "_res_ctl"}, {29'd0, alu_ld, alu_sh_oe, alu_res_oe}, 32'b001);
      check({tag, "_res_hold"}, {22'd0, alu_bus, alu_si, alu_dir_r}, {22'd0, b, si, dr});
      check({tag, "_res_nvalid"}, 32'(resp_valid), 32'd0);
      b = dr ? {si, b[7:1]} : {b[6:0], si};
      tick();
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_result"}, 32'(resp_result), 32'(exp_res));
    check({tag, "_flags"}, 32'(resp_flags), 32'(exp_flags));
    check({tag, "_done_quiet"}, {22'd0, alu_bus, alu_ld, alu_res_oe}, 32'd0);
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_retire"}, {30'd0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_operand = 8'd0;
    req_carry = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    #12;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_alu", {19'd0, alu_bus, alu_ld, alu_sh_oe, alu_res_oe, alu_si, alu_dir_r}, 32'd0);
    check("reset_resp", {19'd0, resp_valid, resp_result, resp_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // resp_ready with nothing pending is ignored
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("idle_rready", {30'd0, resp_valid, req_ready}, 32'b01);

    run_op("srl81", 3'd7, 8'h81, 1'b0, 1, 8'h40, 4'b0001);
    complete("srl81");
    run_op("rr01", 3'd3, 8'h01, 1'b0, 1, 8'h00, 4'b1001);
    complete("rr01");
    run_op("rl80", 3'd2, 8'h80, 1'b1, 1, 8'h01, 4'b0001);
    complete("rl80");
    run_op("swapA5", 3'd6, 8'hA5, 1'b0, 4, 8'h5A, 4'b0000);
    complete("swapA5");

    // SRA with a stalled consumer and a competing request
    run_op("sra80", 3'd5, 8'h80, 1'b0, 1, 8'hC0, 4'b0000);
    req_valid = 1'b1; req_op = 3'd4; req_operand = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sra_hold", {19'd0, resp_valid, resp_result, resp_flags}, {19'd0, 1'b1, 8'hC0, 4'b0000});
      check("sra_noaccept", {30'd0, req_ready, alu_ld}, 32'd0);
    end
    req_valid = 1'b0;
    complete("sra80");

    // flush during SWAP pass 2
    req_valid = 1'b1; req_op = 3'd6; req_operand = 8'hA5; req_carry = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flush_in_load", 32'(alu_ld), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {27'd0, req_ready, resp_valid, alu_ld, alu_res_oe, alu_sh_oe}, 32'b10000);
    check("flush_bus", 32'(alu_bus), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush_noresp", {30'd0, resp_valid, alu_ld}, 32'd0);
    end

    // flush beats a request in IDLE
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_operand = 8'hFF;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_idle_req", {30'd0, req_ready, alu_ld}, 32'b10);

    run_op("slaFF", 3'd4, 8'hFF, 1'b0, 1, 8'hFE, 4'b0001);
    complete("slaFF");

    // reset asserted in RES
    req_valid = 1'b1; req_op = 3'd3; req_operand = 8'h01; req_carry = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_in_res", 32'(alu_res_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_alu_now", {19'd0, alu_bus, alu_ld, alu_sh_oe, alu_res_oe, alu_si, alu_dir_r}, 32'd0);
    check("rst_resp_now", {19'd0, resp_valid, resp_result, resp_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rst_release", {29'd0, req_ready, resp_valid, alu_res_oe}, 32'b100);
    tick();
    check("rst_stays_idle", {30'd0, resp_valid, alu_ld}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
